// File: rtl/lsu_param.sv
// -----------------------------------------------------------------------------
// lsu_param : parametrised per-thread load/store unit
//
// Sequences one memory read (LDR) or write (STR) per instruction through a
// held-valid handshake to the memory controller. Progress is visible to the
// core scheduler through o_lsu_state (IDLE=0, REQUEST=1, WAIT=2, DONE=3).
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   : a WAIT-cycle watchdog aborts a request after TIMEOUT cycles
//               without ready and raises o_lsu_error.
//   undefined : WAIT is unbounded and o_lsu_error is tied to 0.
//
// Ports
//   i_clk                       clock, rising edge
//   i_reset                     synchronous active-high reset
//   i_enable                    thread active (gates launch only)
//   i_core_state[CS_W]          core pipeline stage
//   i_rs[DATA_W]                address operand
//   i_rt[DATA_W]                store data operand
//   i_decoded_mem_read_enable   instruction is LDR
//   i_decoded_mem_write_enable  instruction is STR
//   o_mem_read_valid            read request
//   o_mem_read_address[ADDR_W]  read address
//   i_mem_read_ready            read accepted, data valid
//   i_mem_read_data[DATA_W]     read data
//   o_mem_write_valid           write request
//   o_mem_write_address[ADDR_W] write address
//   o_mem_write_data[DATA_W]    write data
//   i_mem_write_ready           write accepted
//   o_lsu_out[DATA_W]           load result
//   o_lsu_state[2]              FSM state
//   o_lsu_error                 timeout flag
// -----------------------------------------------------------------------------
module lsu_param #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int CS_W       = 3,
   parameter int CS_REQUEST = 1,
   parameter int CS_UPDATE  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [CS_W-1:0]   i_core_state,
   input  logic [DATA_W-1:0] i_rs,
   input  logic [DATA_W-1:0] i_rt,
   input  logic              i_decoded_mem_read_enable,
   input  logic              i_decoded_mem_write_enable,
   output logic              o_mem_read_valid,
   output logic [ADDR_W-1:0] o_mem_read_address,
   input  logic              i_mem_read_ready,
   input  logic [DATA_W-1:0] i_mem_read_data,
   output logic              o_mem_write_valid,
   output logic [ADDR_W-1:0] o_mem_write_address,
   output logic [DATA_W-1:0] o_mem_write_data,
   input  logic              i_mem_write_ready,
   output logic [DATA_W-1:0] o_lsu_out,
   output logic [1:0]        o_lsu_state,
   output logic              o_lsu_error
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_is_read;
   logic              r_rd_valid;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_wr_valid;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_lsu_out;
   logic              w_launch;
   logic              w_accept;
   logic              w_timeout;

`ifdef LSU_TIMEOUT_EN
   // Watchdog counter is at least 8 bits and wide enough to hold TIMEOUT.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] r_cnt;
   logic             r_error;
`else
   // TIMEOUT only feeds the optional watchdog.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT == 0);
`endif

   // Next-state logic and handshake qualifiers.
   always_comb begin
      w_next_state = r_state;
      w_launch     = 1'b0;
      w_accept     = 1'b0;
      w_timeout    = 1'b0;

      // Only the channel of the latched op can complete the transaction.
      if (r_is_read) begin
         w_accept = i_mem_read_ready;
      end else begin
         w_accept = i_mem_write_ready;
      end

`ifdef LSU_TIMEOUT_EN
      // Ready on the expiring edge wins, so timeout requires no accept.
      if ((r_state == ST_WAIT) && !w_accept && (r_cnt >= CNT_W'(TIMEOUT - 1))) begin
         w_timeout = 1'b1;
      end else begin
         w_timeout = 1'b0;
      end
`endif

      case (r_state)
         ST_IDLE: begin
            if (i_enable && (i_core_state == CS_W'(CS_REQUEST)) &&
                (i_decoded_mem_read_enable || i_decoded_mem_write_enable)) begin
               w_launch     = 1'b1;
               w_next_state = ST_REQUEST;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_REQUEST: begin
            w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_accept || w_timeout) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (i_core_state == CS_W'(CS_UPDATE)) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_DONE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Request/response datapath: op latch, held valid/address/data, load result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_is_read  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_addr  <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_lsu_out  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Read wins when both decode enables are set.
               if (w_launch) begin
                  r_is_read <= i_decoded_mem_read_enable;
               end
            end
            ST_REQUEST: begin
               if (r_is_read) begin
                  r_rd_valid <= 1'b1;
                  r_rd_addr  <= i_rs[ADDR_W-1:0];
               end else begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= i_rs[ADDR_W-1:0];
                  r_wr_data  <= i_rt;
               end
            end
            ST_WAIT: begin
               if (w_accept) begin
                  if (r_is_read) begin
                     r_lsu_out  <= i_mem_read_data;
                     r_rd_valid <= 1'b0;
                  end else begin
                     r_wr_valid <= 1'b0;
                  end
               end else if (w_timeout) begin
                  // Abandoned request: drop valid; a load reports zero data.
                  r_rd_valid <= 1'b0;
                  r_wr_valid <= 1'b0;
                  if (r_is_read) begin
                     r_lsu_out <= '0;
                  end
               end
            end
            ST_DONE: begin
               r_rd_valid <= 1'b0;
               r_wr_valid <= 1'b0;
            end
            default: begin
               r_rd_valid <= 1'b0;
               r_wr_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LSU_TIMEOUT_EN
   // WAIT-cycle watchdog and sticky error flag (cleared by the next launch).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_error <= 1'b0;
      end else begin
         if (r_state == ST_REQUEST) begin
            r_cnt <= '0;
         end else if ((r_state == ST_WAIT) && !w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_launch) begin
            r_error <= 1'b0;
         end else if (w_timeout) begin
            r_error <= 1'b1;
         end
      end
   end

   assign o_lsu_error = r_error;
`else
   assign o_lsu_error = 1'b0;
`endif

   assign o_lsu_state         = r_state;
   assign o_mem_read_valid    = r_rd_valid;
   assign o_mem_read_address  = r_rd_addr;
   assign o_mem_write_valid   = r_wr_valid;
   assign o_mem_write_address = r_wr_addr;
   assign o_mem_write_data    = r_wr_data;
   assign o_lsu_out           = r_lsu_out;

endmodule
